hpm_counter_bank: RTL and testbench



---
 rtl/hpm_counter_bank_pkg.sv | 60 ++++++
 rtl/hpm_counter_bank_slice.sv | 65 ++++++
 rtl/hpm_counter_bank.sv | 189 ++++++++++++++++++
 tb/tb_hpm_counter_bank.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hpm_counter_bank_pkg.sv
// -----------------------------------------------------------------------------
// hpm_counter_bank_pkg
//   Shared definitions for the machine performance-counter bank: CSR address
//   bases, the overflow bit position inside mhpmeventN, the selector width
//   helper, the CSR region decode and the slot -> counter-number mapping.
//   No ports (package).
// -----------------------------------------------------------------------------
package hpm_counter_bank_pkg;

    // CSR address bases; the low five bits carry the counter number N.
    localparam logic [11:0] CSR_MHPMCOUNTER_BASE  = 12'hB00;
    localparam logic [11:0] CSR_MHPMCOUNTERH_BASE = 12'hB80;
    localparam logic [11:0] CSR_MHPMEVENT_BASE    = 12'h320;
    localparam logic [11:0] CSR_MCOUNTINHIBIT     = 12'h320;

    // Overflow flag position inside mhpmeventN.
    localparam int unsigned OF_BIT = 31;

    // Counter numbers inside each CSR region.
    localparam logic [4:0] CNT_MCYCLE    = 5'd0;
    localparam logic [4:0] CNT_MINSTRET  = 5'd2;
    localparam logic [4:0] CNT_HPM_FIRST = 5'd3;

    typedef enum logic [1:0] {
        REGION_NONE,
        REGION_COUNTER_LO,
        REGION_COUNTER_HI,
        REGION_EVENT
    } csr_region_e;

    // Bits needed to hold selector values 0..num_events.
    function automatic int unsigned sel_width(input int unsigned num_events);
        return $clog2(num_events + 1);
    endfunction

    // Slot 0 = mcycle, slot 1 = minstret, slot k >= 2 = mhpmcounter(k+1).
    function automatic logic [4:0] slot_csr_num(input int unsigned slot);
        if (slot == 0) begin
            return CNT_MCYCLE;
        end else if (slot == 1) begin
            return CNT_MINSTRET;
        end else begin
            return 5'(slot + 1);
        end
    endfunction

    // Which 32-entry CSR window an index falls into (counter number ignored).
    function automatic csr_region_e decode_region(input logic [11:0] idx);
        if (idx[11:5] == CSR_MHPMCOUNTER_BASE[11:5]) begin
            return REGION_COUNTER_LO;
        end else if (idx[11:5] == CSR_MHPMCOUNTERH_BASE[11:5]) begin
            return REGION_COUNTER_HI;
        end else if (idx[11:5] == CSR_MHPMEVENT_BASE[11:5]) begin
            return REGION_EVENT;
        end else begin
            return REGION_NONE;
        end
    endfunction

endpackage

// File: rtl/hpm_counter_bank_slice.sv
// -----------------------------------------------------------------------------
// hpm_counter_slice
//   One performance counter: COUNTER_WIDTH-bit value with 32-bit low/high half
//   writes, inhibit, single-step increment and a sticky overflow flag set on a
//   wrap from all-ones to zero.
// Ports
//   clk, reset      clock, synchronous active-high reset
//   inhibit         registered inhibit bit for this counter
//   increment       count request this cycle
//   write_lo/hi     replace bits[31:0] / bits[COUNTER_WIDTH-1:32]
//   write_data      CSR write data
//   of_write        load overflow flag with of_write_value (wins over a wrap)
//   count           current counter value
//   overflow        sticky overflow flag
// -----------------------------------------------------------------------------
module hpm_counter_slice #(
    parameter int unsigned COUNTER_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inhibit,
    input  logic                     increment,
    input  logic                     write_lo,
    input  logic                     write_hi,
    input  logic [31:0]              write_data,
    input  logic                     of_write,
    input  logic                     of_write_value,
    output logic [COUNTER_WIDTH-1:0] count,
    output logic                     overflow
);

    localparam int unsigned HI_W = COUNTER_WIDTH - 32;

    logic [COUNTER_WIDTH-1:0] count_q;
    logic                     overflow_q;
    logic                     bump;

    // A write to either half drops the increment for that cycle.
    assign bump = increment && !inhibit && !write_lo && !write_hi;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (write_lo) begin
                count_q[31:0] <= write_data;
            end else if (write_hi) begin
                count_q[COUNTER_WIDTH-1:32] <= write_data[HI_W-1:0];
            end else if (bump) begin
                count_q <= count_q + COUNTER_WIDTH'(1);
            end

            if (of_write) begin
                overflow_q <= of_write_value;
            end else if (bump && (&count_q)) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/hpm_counter_bank.sv
// -----------------------------------------------------------------------------
// hpm_counter_bank
//   Machine performance-counter bank: mcycle, minstret and NUM_HPM
//   mhpmcounterN with mhpmeventN selectors, mcountinhibit, sticky per-counter
//   overflow and a level overflow interrupt.
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   csr_read_enable/index       combinational read request
//   csr_read_data/hit           read value (0 unless hit) and hit flag
//   csr_write_enable/index/data CSR write port
//   instr_retired               minstret increment source
//   hpm_event[NUM_EVENTS]       event pulses selected by mhpmeventN
//   overflow_irq                OR of all overflow flags
// -----------------------------------------------------------------------------
module hpm_counter_bank
    import hpm_counter_bank_pkg::*;
#(
    parameter int unsigned NUM_HPM       = 4,
    parameter int unsigned COUNTER_WIDTH = 64,
    parameter int unsigned NUM_EVENTS    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  csr_read_enable,
    input  logic [11:0]           csr_read_index,
    output logic [31:0]           csr_read_data,
    output logic                  csr_read_hit,
    input  logic                  csr_write_enable,
    input  logic [11:0]           csr_write_index,
    input  logic [31:0]           csr_write_data,
    input  logic                  instr_retired,
    input  logic [NUM_EVENTS-1:0] hpm_event,
    output logic                  overflow_irq
);

    localparam int unsigned NUM_SLOTS = NUM_HPM + 2;
    localparam int unsigned SEL_W     = sel_width(NUM_EVENTS);
    localparam int unsigned HI_W      = COUNTER_WIDTH - 32;

    // Implemented mcountinhibit bits: one per counter number in use.
    function automatic logic [31:0] inhibit_mask();
        logic [31:0] m;
        m = '0;
        for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
            m[slot_csr_num(s)] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [31:0] INHIBIT_MASK = inhibit_mask();

    logic [COUNTER_WIDTH-1:0] count [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]     of_bits;
    logic [NUM_SLOTS-1:0]     wr_lo;
    logic [NUM_SLOTS-1:0]     wr_hi;
    logic [NUM_SLOTS-1:0]     of_wr;
    logic [NUM_SLOTS-1:0]     of_wr_val;
    logic [NUM_SLOTS-1:0]     inc_src;
    logic [NUM_SLOTS-1:0]     inh_slot;
    logic [NUM_HPM-1:0]       ev_wr;
    logic                     inh_wr;
    logic [SEL_W-1:0]         sel_q [NUM_HPM];
    logic [31:0]              inhibit_q;

    csr_region_e wr_region;
    csr_region_e rd_region;
    logic [4:0]  wr_n;
    logic [4:0]  rd_n;

    assign wr_region = decode_region(csr_write_index);
    assign rd_region = decode_region(csr_read_index);
    assign wr_n      = csr_write_index[4:0];
    assign rd_n      = csr_read_index[4:0];

    // Write decode into per-slot strobes.
    always_comb begin
        wr_lo     = '0;
        wr_hi     = '0;
        of_wr     = '0;
        of_wr_val = '0;
        ev_wr     = '0;
        inh_wr    = 1'b0;
        if (csr_write_enable) begin
            for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
                if (wr_n == slot_csr_num(s)) begin
                    wr_lo[s] = (wr_region == REGION_COUNTER_LO);
                    wr_hi[s] = (wr_region == REGION_COUNTER_HI);
                end
            end
            for (int unsigned h = 0; h < NUM_HPM; h++) begin
                if (wr_region == REGION_EVENT && wr_n == slot_csr_num(h + 2)) begin
                    ev_wr[h]         = 1'b1;
                    of_wr[h + 2]     = 1'b1;
                    of_wr_val[h + 2] = csr_write_data[OF_BIT];
                end
            end
            inh_wr = (wr_region == REGION_EVENT) && (wr_n == CNT_MCYCLE);
        end
        // mcycle/minstret flags have no CSR of their own; a low-half write clears them.
        of_wr[0] = wr_lo[0];
        of_wr[1] = wr_lo[1];
    end

    // Increment sources and per-slot inhibit bits.
    always_comb begin
        inc_src    = '0;
        inc_src[0] = 1'b1;
        inc_src[1] = instr_retired;
        for (int unsigned h = 0; h < NUM_HPM; h++) begin
            for (int unsigned e = 0; e < NUM_EVENTS; e++) begin
                if (sel_q[h] == SEL_W'(e + 1)) begin
                    inc_src[h + 2] = hpm_event[e];
                end
            end
        end
        for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
            inh_slot[s] = inhibit_q[slot_csr_num(s)];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inhibit_q <= '0;
            for (int unsigned h = 0; h < NUM_HPM; h++) begin
                sel_q[h] <= '0;
            end
        end else begin
            if (inh_wr) begin
                inhibit_q <= csr_write_data & INHIBIT_MASK;
            end
            for (int unsigned h = 0; h < NUM_HPM; h++) begin
                if (ev_wr[h]) begin
                    sel_q[h] <= csr_write_data[SEL_W-1:0];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        hpm_counter_slice #(
            .COUNTER_WIDTH(COUNTER_WIDTH)
        ) u_slice (
            .clk            (clk),
            .reset          (reset),
            .inhibit        (inh_slot[g]),
            .increment      (inc_src[g]),
            .write_lo       (wr_lo[g]),
            .write_hi       (wr_hi[g]),
            .write_data     (csr_write_data),
            .of_write       (of_wr[g]),
            .of_write_value (of_wr_val[g]),
            .count          (count[g]),
            .overflow       (of_bits[g])
        );
    end

    // Read mux: pre-edge register values.
    always_comb begin
        csr_read_data = '0;
        csr_read_hit  = 1'b0;
        if (csr_read_enable) begin
            for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
                if (rd_n == slot_csr_num(s)) begin
                    if (rd_region == REGION_COUNTER_LO) begin
                        csr_read_hit  = 1'b1;
                        csr_read_data = count[s][31:0];
                    end else if (rd_region == REGION_COUNTER_HI) begin
                        csr_read_hit  = 1'b1;
                        csr_read_data[HI_W-1:0] = count[s][COUNTER_WIDTH-1:32];
                    end
                end
            end
            for (int unsigned h = 0; h < NUM_HPM; h++) begin
                if (rd_region == REGION_EVENT && rd_n == slot_csr_num(h + 2)) begin
                    csr_read_hit                = 1'b1;
                    csr_read_data[SEL_W-1:0]    = sel_q[h];
                    csr_read_data[OF_BIT]       = of_bits[h + 2];
                end
            end
            if (rd_region == REGION_EVENT && rd_n == CNT_MCYCLE) begin
                csr_read_hit  = 1'b1;
                csr_read_data = inhibit_q;
            end
        end
    end

    assign overflow_irq = |of_bits;

endmodule

// File: tb/tb_hpm_counter_bank.sv
// -----------------------------------------------------------------------------
// tb_hpm_counter_bank
//   Directed bench for hpm_counter_bank with default parameters
//   (NUM_HPM=4, COUNTER_WIDTH=64, NUM_EVENTS=16). Inputs are driven 1ns after
//   the rising edge; reads sample 1ns after the inputs settle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hpm_counter_bank;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        csr_read_enable = 1'b0;
    logic [11:0] csr_read_index = '0;
    logic [31:0] csr_read_data;
    logic        csr_read_hit;
    logic        csr_write_enable = 1'b0;
    logic [11:0] csr_write_index = '0;
    logic [31:0] csr_write_data = '0;
    logic        instr_retired = 1'b0;
    logic [15:0] hpm_event = '0;
    logic        overflow_irq;

    int unsigned checks = 0;
    int unsigned failures = 0;

    hpm_counter_bank #(
        .NUM_HPM       (4),
        .COUNTER_WIDTH (64),
        .NUM_EVENTS    (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .csr_read_enable  (csr_read_enable),
        .csr_read_index   (csr_read_index),
        .csr_read_data    (csr_read_data),
        .csr_read_hit     (csr_read_hit),
        .csr_write_enable (csr_write_enable),
        .csr_write_index  (csr_write_index),
        .csr_write_data   (csr_write_data),
        .instr_retired    (instr_retired),
        .hpm_event        (hpm_event),
        .overflow_irq     (overflow_irq)
    );

    always #50 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic csr_read(input logic [11:0] idx, output logic [31:0] data, output logic hit);
        csr_read_enable = 1'b1;
        csr_read_index  = idx;
        #1;
        data = csr_read_data;
        hit  = csr_read_hit;
        csr_read_enable = 1'b0;
    endtask

    task automatic check_read(input string tag, input logic [11:0] idx, input logic [31:0] exp);
        logic [31:0] d;
        logic        h;
        csr_read(idx, d, h);
        check(tag, {32'd0, d}, {32'd0, exp});
    endtask

    task automatic check_unmapped(input string tag, input logic [11:0] idx);
        logic [31:0] d;
        logic        h;
        csr_read(idx, d, h);
        check({tag, "_data"}, {32'd0, d}, 64'd0);
        check({tag, "_hit"}, {63'd0, h}, 64'd0);
    endtask

    task automatic csr_write(input logic [11:0] idx, input logic [31:0] data);
        csr_write_enable = 1'b1;
        csr_write_index  = idx;
        csr_write_data   = data;
        tick(1);
        csr_write_enable = 1'b0;
    endtask

    task automatic pulse_event(input logic [15:0] mask, input int unsigned n);
        repeat (n) begin
            hpm_event = mask;
            tick(1);
            hpm_event = '0;
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        h;

        // Reset, then idle 10 cycles.
        tick(3);
        reset = 1'b0;
        check_read("rst_mcycle", 12'hB00, 32'd0);
        check_read("rst_minstret", 12'hB02, 32'd0);
        check_read("rst_hpm3", 12'hB03, 32'd0);
        check_read("rst_inhibit", 12'h320, 32'd0);
        check("rst_irq", {63'd0, overflow_irq}, 64'd0);
        tick(10);
        check_read("idle_mcycle", 12'hB00, 32'd10);
        check_read("idle_minstret", 12'hB02, 32'd0);
        check("idle_irq", {63'd0, overflow_irq}, 64'd0);

        // Event selection.
        csr_write(12'h323, 32'd2);
        pulse_event(16'h0002, 5);
        pulse_event(16'h0001, 3);
        check_read("sel_hpm3", 12'hB03, 32'd5);
        check_read("sel_hpm3h", 12'hB83, 32'd0);
        check_read("sel_hpm4", 12'hB04, 32'd0);
        check_read("sel_hpm6", 12'hB06, 32'd0);
        check_read("sel_evt3", 12'h323, 32'd2);

        // Selector boundaries: 17 never counts, 16 selects hpm_event[15].
        csr_write(12'h324, 32'd17);
        csr_write(12'h325, 32'd16);
        pulse_event(16'hFFFF, 2);
        check_read("bnd_hpm3", 12'hB03, 32'd7);
        check_read("bnd_hpm4", 12'hB04, 32'd0);
        check_read("bnd_hpm5", 12'hB05, 32'd2);
        check_read("bnd_evt4", 12'h324, 32'h11);
        csr_write(12'h326, 32'h7FFF_FFE3);
        check_read("evt_mask", 12'h326, 32'h3);

        // Wrap sets sticky OF; mhpmevent write clears it.
        csr_write(12'hB03, 32'hFFFF_FFFF);
        csr_write(12'hB83, 32'hFFFF_FFFF);
        check_read("ones_lo", 12'hB03, 32'hFFFF_FFFF);
        check_read("ones_hi", 12'hB83, 32'hFFFF_FFFF);
        check("ones_irq", {63'd0, overflow_irq}, 64'd0);
        pulse_event(16'h0002, 1);
        check_read("wrap_lo", 12'hB03, 32'd0);
        check_read("wrap_hi", 12'hB83, 32'd0);
        check_read("wrap_evt3", 12'h323, 32'h8000_0002);
        check("wrap_irq", {63'd0, overflow_irq}, 64'd1);
        csr_write(12'h323, 32'd2);
        check("ofclr_irq", {63'd0, overflow_irq}, 64'd0);
        check_read("ofclr_evt3", 12'h323, 32'd2);

        // Wrap in the same cycle as an mhpmevent write with bit31=0.
        csr_write(12'hB03, 32'hFFFF_FFFF);
        csr_write(12'hB83, 32'hFFFF_FFFF);
        hpm_event = 16'h0002;
        csr_write(12'h323, 32'd2);
        hpm_event = '0;
        check_read("wrapwr_lo", 12'hB03, 32'd0);
        check_read("wrapwr_evt3", 12'h323, 32'd2);
        check("wrapwr_irq", {63'd0, overflow_irq}, 64'd0);

        // mcycle wrap: flag visible only on irq, cleared by low-half write.
        csr_write(12'hB80, 32'hFFFF_FFFF);
        csr_write(12'hB00, 32'hFFFF_FFFF);
        check("mcyc_pre_irq", {63'd0, overflow_irq}, 64'd0);
        tick(1);
        check_read("mcyc_wrap_hi", 12'hB80, 32'd0);
        check("mcyc_wrap_irq", {63'd0, overflow_irq}, 64'd1);
        csr_write(12'hB00, 32'd0);
        check("mcyc_clr_irq", {63'd0, overflow_irq}, 64'd0);

        // Low write collides with increment: write wins, high kept.
        csr_write(12'hB80, 32'd5);
        csr_write(12'hB00, 32'h100);
        check_read("wcol_lo0", 12'hB00, 32'h100);
        check_read("wcol_hi0", 12'hB80, 32'd5);
        tick(1);
        check_read("wcol_lo1", 12'hB00, 32'h101);
        check_read("wcol_hi1", 12'hB80, 32'd5);

        // mcountinhibit on minstret, then release with retire active across the write.
        csr_write(12'h320, 32'd4);
        check_read("inh_rd", 12'h320, 32'd4);
        instr_retired = 1'b1;
        tick(4);
        instr_retired = 1'b0;
        check_read("inh_minstret", 12'hB02, 32'd0);
        instr_retired = 1'b1;
        csr_write(12'h320, 32'd0);
        check_read("inh_release0", 12'hB02, 32'd0);
        tick(1);
        check_read("inh_release1", 12'hB02, 32'd1);
        instr_retired = 1'b0;
        csr_write(12'h320, 32'hFFFF_FFFF);
        check_read("inh_mask", 12'h320, 32'h0000_007D);
        csr_write(12'hB00, 32'h55);
        tick(3);
        check_read("inh_mcycle", 12'hB00, 32'h55);
        csr_write(12'h320, 32'd0);

        // Unimplemented indices and disabled read.
        check_unmapped("un_3ff", 12'h3FF);
        check_unmapped("un_evt7", 12'h327);
        check_unmapped("un_hpm7", 12'hB07);
        check_unmapped("un_hpm7h", 12'hB87);
        check_unmapped("un_b01", 12'hB01);
        check_unmapped("un_321", 12'h321);
        csr_read(12'hB02, d, h);
        check("hit_minstret", {63'd0, h}, 64'd1);
        csr_read_enable = 1'b0;
        csr_read_index  = 12'hB00;
        #1;
        check("noen_data", {32'd0, csr_read_data}, 64'd0);
        check("noen_hit", {63'd0, csr_read_hit}, 64'd0);

        // Reset mid-operation, with a write and events in the same cycle.
        csr_write(12'h325, 32'h8000_0010);
        check("pre_rst_irq", {63'd0, overflow_irq}, 64'd1);
        reset            = 1'b1;
        csr_write_enable = 1'b1;
        csr_write_index  = 12'hB00;
        csr_write_data   = 32'h1234;
        instr_retired    = 1'b1;
        hpm_event        = 16'hFFFF;
        tick(1);
        reset            = 1'b0;
        csr_write_enable = 1'b0;
        instr_retired    = 1'b0;
        hpm_event        = '0;
        check_read("mrst_mcycle", 12'hB00, 32'd0);
        check_read("mrst_mcycleh", 12'hB80, 32'd0);
        check_read("mrst_minstret", 12'hB02, 32'd0);
        check_read("mrst_hpm3", 12'hB03, 32'd0);
        check_read("mrst_hpm5", 12'hB05, 32'd0);
        check_read("mrst_evt3", 12'h323, 32'd0);
        check_read("mrst_evt5", 12'h325, 32'd0);
        check_read("mrst_inhibit", 12'h320, 32'd0);
        check("mrst_irq", {63'd0, overflow_irq}, 64'd0);
        tick(1);
        check_read("post_rst_mcycle", 12'hB00, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
